// File: rtl/formula_result_credit_drain.sv
// formula_result_credit_drain
// Consumer end of a fixed-latency, no-backpressure formula pipe. Every argument
// issued upstream reserves a result slot, so the FIFO can never legitimately
// overflow. Returning results are buffered and presented on a valid/ready port.
//
// Ports
//   clk, rst           clock, asynchronous active-low reset
//   arg_vld / arg_rdy  argument issue handshake (arg_rdy = free credit)
//   res_vld / res      pipe result beat (no backpressure)
//   out_vld / out_rdy  downstream handshake, out_data = FIFO head
//   credits            current free credits
//   err                sticky protocol error
//
// Optional build macro FORMULA_DRAIN_LATENCY_CHECK_EN adds a latency checker:
// a shift register of issue bits predicts res_vld, and any disagreement sets err.
module formula_result_credit_drain #(
    parameter int unsigned width   = 32,
    parameter int unsigned depth   = 8,
    parameter int unsigned latency = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         arg_vld,
    output logic                         arg_rdy,
    input  logic                         res_vld,
    input  logic [width-1:0]             res,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic [width-1:0]             out_data,
    output logic [$clog2(depth+1)-1:0]   credits,
    output logic                         err
);

    localparam int unsigned CNT_W = $clog2(depth + 1);
    localparam int unsigned PTR_W = (depth > 1) ? $clog2(depth) : 1;

    logic [CNT_W-1:0] cred_q, cred_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [width-1:0] mem_q [depth];
    logic [width-1:0] mem_d [depth];
    logic             out_vld_q, out_vld_d;
    logic             err_q, err_d;

    logic issue;
    logic pop;
    logic full;
    logic push_ok;
    logic overflow;
    logic chk_err;

`ifdef FORMULA_DRAIN_LATENCY_CHECK_EN
    logic [latency-1:0] sr_q, sr_d;

    // The oldest issue bit is the res_vld we expect this cycle.
    always_comb begin
        sr_d    = latency'({sr_q, issue});
        chk_err = (res_vld != sr_q[latency-1]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end
`else
    assign chk_err = 1'b0;
`endif

    // Handshake decode; a push into a full FIFO is allowed only when the head leaves.
    always_comb begin
        issue    = arg_vld & (cred_q != '0);
        pop      = out_vld_q & out_rdy;
        full     = (occ_q == CNT_W'(depth));
        push_ok  = res_vld & (~full | pop);
        overflow = res_vld & full & ~pop;
    end

    // Next-state for credits, occupancy, pointers, storage and error.
    always_comb begin
        cred_d   = cred_q;
        occ_d    = occ_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        err_d    = err_q | overflow | chk_err;

        // A returned credit is only counted while below depth, so credits saturate.
        if (issue && !pop) begin
            cred_d = cred_q - CNT_W'(1);
        end else if (pop && !issue && (cred_q != CNT_W'(depth))) begin
            cred_d = cred_q + CNT_W'(1);
        end

        if (push_ok && !pop) begin
            occ_d = occ_q + CNT_W'(1);
        end else if (pop && !push_ok) begin
            occ_d = occ_q - CNT_W'(1);
        end

        if (push_ok) begin
            mem_d[wr_ptr_q] = res;
            wr_ptr_d = (wr_ptr_q == PTR_W'(depth - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end

        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(depth - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end

        out_vld_d = (occ_d != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cred_q    <= CNT_W'(depth);
            occ_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            mem_q     <= '{default: '0};
            out_vld_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            cred_q    <= cred_d;
            occ_q     <= occ_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            mem_q     <= mem_d;
            out_vld_q <= out_vld_d;
            err_q     <= err_d;
        end
    end

    assign arg_rdy  = (cred_q != '0);
    assign credits  = cred_q;
    assign out_vld  = out_vld_q;
    assign out_data = mem_q[rd_ptr_q];
    assign err      = err_q;

endmodule

// File: tb/tb_formula_result_credit_drain.sv
// Bench for formula_result_credit_drain: a driver issues arguments and models the
// pipe, pushing expected beats into a scoreboard queue; a separate monitor checks
// the FIFO head whenever out_vld is high and pops on acceptance.
module tb_formula_result_credit_drain;

    localparam int unsigned W  = 32;
    localparam int unsigned D  = 8;
    localparam int unsigned L  = 16;
    localparam int unsigned CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          arg_vld = 1'b0;
    logic          arg_rdy;
    logic          res_vld = 1'b0;
    logic [W-1:0]  res = '0;
    logic          out_vld;
    logic          out_rdy = 1'b0;
    logic [W-1:0]  out_data;
    logic [CW-1:0] credits;
    logic          err;

    always #5 clk = ~clk;

    formula_result_credit_drain #(.width(W), .depth(D), .latency(L)) dut (
        .clk      (clk),
        .rst      (rst),
        .arg_vld  (arg_vld),
        .arg_rdy  (arg_rdy),
        .res_vld  (res_vld),
        .res      (res),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .credits  (credits),
        .err      (err)
    );

    // Reference model state (describes the DUT state after the latest edge).
    int           m_cred;
    int           m_occ;
    bit           m_err;
`ifdef FORMULA_DRAIN_LATENCY_CHECK_EN
    logic [L-1:0] m_sr;
`endif
    logic [W-1:0] exp_q [$];
    int           due_q [$];
    logic [W-1:0] dat_q [$];
    int           cyc;
    int           pipe_lat;
    logic [W-1:0] next_res;
    int           pops;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic model_reset();
        m_cred   = D;
        m_occ    = 0;
        m_err    = 1'b0;
`ifdef FORMULA_DRAIN_LATENCY_CHECK_EN
        m_sr     = '0;
`endif
        exp_q.delete();
        due_q.delete();
        dat_q.delete();
        next_res = 32'h1;
        pops     = 0;
    endtask

    task automatic rst_seq();
        @(negedge clk);
        rst     = 1'b0;
        arg_vld = 1'b0;
        res_vld = 1'b0;
        res     = '0;
        out_rdy = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("rst_credits", 32'(credits), 32'(D));
        check("rst_arg_rdy", 32'(arg_rdy), 32'd1);
        check("rst_out_vld", 32'(out_vld), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b1;
    endtask

    // One cycle: drive inputs, check status against the model, advance the model.
    task automatic step(input bit av, input bit ordy, input bit frc, input logic [W-1:0] fdat);
        bit iss;
        bit pp;
        bit acc;
        bit due_now;
        @(negedge clk);
        cyc++;
        due_now = (due_q.size() > 0) && (due_q[0] == cyc);
        arg_vld = av;
        out_rdy = ordy;
        res_vld = due_now | frc;
        res     = due_now ? dat_q[0] : (frc ? fdat : '0);
        if (due_now) begin
            void'(due_q.pop_front());
            void'(dat_q.pop_front());
        end
        #1;
        check("credits", 32'(credits), 32'(m_cred));
        check("arg_rdy", 32'(arg_rdy), 32'(m_cred != 0));
        check("out_vld", 32'(out_vld), 32'(m_occ != 0));
        check("err", 32'(err), 32'(m_err));

        iss = av && (m_cred != 0);
        pp  = ordy && (m_occ != 0);
        acc = 1'b0;
        if (res_vld) begin
            if ((m_occ < D) || pp) begin
                acc = 1'b1;
                exp_q.push_back(res);
            end else begin
                m_err = 1'b1;
            end
        end
`ifdef FORMULA_DRAIN_LATENCY_CHECK_EN
        if (res_vld != m_sr[L-1]) m_err = 1'b1;
        m_sr = {m_sr[L-2:0], iss};
`endif
        if (acc && !pp) m_occ++;
        else if (pp && !acc) m_occ--;
        if (iss && !pp) m_cred--;
        else if (pp && !iss && (m_cred < D)) m_cred++;
        if (iss) begin
            due_q.push_back(cyc + pipe_lat);
            dat_q.push_back(next_res);
            next_res++;
        end
    endtask

    // Monitor: head must match the oldest expected beat; pop on acceptance.
    always @(negedge clk) begin
        #2;
        if (rst && out_vld) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL out_data: got 0x%0h with out_vld=1, expected no beat (cycle %0d)", out_data, cyc);
            end else begin
                check("out_data", out_data, exp_q[0]);
                if (out_rdy) begin
                    void'(exp_q.pop_front());
                    pops++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc      = 0;
        pipe_lat = L;
        model_reset();
        rst_seq();

        // Credit exhaustion with downstream stalled, then collect all 8 results.
        repeat (10) step(1'b1, 1'b0, 1'b0, '0);
        repeat (18) step(1'b0, 1'b0, 1'b0, '0);
        check("exhaust_stored", 32'(exp_q.size()), 32'(D));

        // Full FIFO: push and pop together, then overflow with downstream stalled.
        step(1'b0, 1'b1, 1'b1, 32'hA5A5_0001);
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        repeat (3) step(1'b0, 1'b0, 1'b0, '0);
        repeat (12) step(1'b0, 1'b1, 1'b0, '0);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        // Streaming 0x1..0x40 with downstream always ready.
        rst_seq();
        for (int i = 0; i < 600; i++) begin
            if ((next_res > 32'h40) && (due_q.size() == 0) && (exp_q.size() == 0)) break;
            step(next_res <= 32'h40, 1'b1, 1'b0, '0);
        end
        step(1'b0, 1'b1, 1'b0, '0);
        check("stream_pops", 32'(pops), 32'd64);
        check("stream_empty", 32'(exp_q.size()), 32'd0);

        // Result returning one cycle early.
        rst_seq();
        pipe_lat = L - 1;
        step(1'b1, 1'b0, 1'b0, '0);
        pipe_lat = L;
        repeat (20) step(1'b0, 1'b1, 1'b0, '0);
        check("early_drained", 32'(pops), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
